// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq -- 32x32 -> 64-bit unsigned sequential shift-and-add multiplier.
//
// One multiplier bit is retired per clock.
//   * The control unit (mul_seq_ctrl) holds the FSM, the iteration counter and
//     the registered busy/done outputs.
//   * The datapath (mul_seq_dp) holds the operand registers, the accumulator,
//     the shifter and the result register.
//
// Timing: if start is accepted at edge N, done=1 and the new result are
// visible in the cycle after edge N+33. The latency does not depend on the
// operand values.
//
// Ports (top level):
//   CLK     in   1   clock; all state changes on the rising edge
//   reset   in   1   asynchronous, active-low reset
//   start   in   1   request pulse; accepted only while idle
//   a       in  32   unsigned multiplicand, captured on accept
//   b       in  32   unsigned multiplier, captured on accept
//   busy    out  1   high from accept until the done pulse
//   done    out  1   one-cycle pulse; result is valid
//   result  out 64   product; held until the next completed operation
// -----------------------------------------------------------------------------

// Control unit: IDLE -> RUN (32 cycles) -> DONE -> IDLE.
module mul_seq_ctrl (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  output logic load_o,    // capture operands this edge
  output logic step_o,    // perform one add/shift step this edge
  output logic finish_o,  // load the result register this edge
  output logic busy_o,
  output logic done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [4:0] cnt_q;
  logic       busy_q;
  logic       done_q;

  // Datapath strobes are decoded from the current state. A start that
  // arrives outside IDLE is simply dropped.
  assign load_o   = (state_q == ST_IDLE) && start_i;
  assign step_o   = (state_q == ST_RUN);
  assign finish_o = (state_q == ST_DONE);
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  // FSM, iteration counter and registered busy/done.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          done_q <= 1'b0;
          busy_q <= 1'b1;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          // The done pulse and the new result appear together, once busy drops.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 5'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// Datapath: operand registers, 33-bit adder, combined shifter, result register.
module mul_seq_dp (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        finish_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o
);

  logic [31:0] mcand_q;   // multiplicand
  logic [31:0] acc_hi_q;  // upper accumulator half
  logic [31:0] mplier_q;  // multiplier; product bits shift in from the top
  logic [63:0] result_q;
  logic [32:0] sum_s;

  // Conditional add into the upper accumulator half. The carry is kept in bit 32.
  always_comb begin
    sum_s = {1'b0, acc_hi_q};
    if (mplier_q[0]) begin
      sum_s = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    end else begin
      sum_s = {1'b0, acc_hi_q};
    end
  end

  // Operand capture and the per-cycle right shift of {carry, acc_hi, mplier}.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_q  <= 32'd0;
      acc_hi_q <= 32'd0;
      mplier_q <= 32'd0;
    end else if (load_i) begin
      mcand_q  <= a_i;
      acc_hi_q <= 32'd0;
      mplier_q <= b_i;
    end else if (step_i) begin
      acc_hi_q <= sum_s[32:1];
      mplier_q <= {sum_s[0], mplier_q[31:1]};
    end else begin
      mcand_q  <= mcand_q;
      acc_hi_q <= acc_hi_q;
      mplier_q <= mplier_q;
    end
  end

  // The result register changes only when the operation completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= 64'd0;
    end else if (finish_i) begin
      result_q <= {acc_hi_q, mplier_q};
    end else begin
      result_q <= result_q;
    end
  end

  assign result_o = result_q;

endmodule

// Top level: joins the control unit to the datapath.
module mul_seq (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  logic load_s;
  logic step_s;
  logic finish_s;

  mul_seq_ctrl u_ctrl (
    .clk_i    (CLK),
    .rst_n_i  (reset),
    .start_i  (start),
    .load_o   (load_s),
    .step_o   (step_s),
    .finish_o (finish_s),
    .busy_o   (busy),
    .done_o   (done)
  );

  mul_seq_dp u_dp (
    .clk_i    (CLK),
    .rst_n_i  (reset),
    .load_i   (load_s),
    .step_i   (step_s),
    .finish_i (finish_s),
    .a_i      (a),
    .b_i      (b),
    .result_o (result)
  );

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mul_seq. Each accepted request pushes its expected
// product onto a scoreboard queue. Each done pulse pops one entry and compares
// it with result.
// -----------------------------------------------------------------------------
module tb_mul_seq;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int n_checks;
  int n_pass;
  logic [63:0] exp_q[$];

  mul_seq dut (
    .CLK    (CLK),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  // Drive a one-cycle start. Returns just after the accepting edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit hold);
    @(negedge CLK);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge CLK);
    exp_q.push_back(model(x, y));
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait for done, counting edges. cyc = -1 when the bound expires.
  task automatic wait_done(output int cyc);
    int i;
    cyc = -1;
    i = 0;
    while (cyc < 0 && i < 60) begin
      @(posedge CLK);
      #1;
      i++;
      if (done) cyc = i;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    #3;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_checks++;
    if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_basic;
    int busy_cnt;
    int cyc;
    logic [63:0] e;
    issue(32'd3, 32'd5, 1'b0);
    busy_cnt = busy ? 1 : 0;
    cyc = -1;
    for (int i = 1; i <= 60 && cyc < 0; i++) begin
      @(posedge CLK);
      #1;
      if (busy) busy_cnt++;
      if (done) cyc = i;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 33) $display("FAIL basic_latency got %0d want 33", cyc); else n_pass++;
    n_checks++;
    if (busy_cnt !== 33) $display("FAIL basic_busy_cycles got %0d want 33", busy_cnt); else n_pass++;
    n_checks++;
    if (result !== e || e !== 64'h0000_0000_0000_000F)
      $display("FAIL basic_result got %h want %h", result, 64'h0000_0000_0000_000F);
    else n_pass++;
    @(posedge CLK);
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_width got %0b want 0", done); else n_pass++;
  endtask

  task automatic test_max;
    int cyc;
    logic [63:0] e;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 33 || result !== 64'hFFFF_FFFE_0000_0001 || result !== e)
      $display("FAIL max_ffff got %h lat %0d want %h lat 33", result, cyc, 64'hFFFF_FFFE_0000_0001);
    else n_pass++;
    issue(32'h8000_0000, 32'd2, 1'b0);
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 33 || result !== 64'h0000_0001_0000_0000 || result !== e)
      $display("FAIL max_msb got %h lat %0d want %h lat 33", result, cyc, 64'h0000_0001_0000_0000);
    else n_pass++;
  endtask

  task automatic test_zero;
    int cyc;
    bit held;
    logic [63:0] e;
    issue(32'd0, 32'h1234_5678, 1'b0);
    held = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 60 && cyc < 0; i++) begin
      @(posedge CLK);
      #1;
      if (done) cyc = i;
      else if (result !== 64'h0000_0001_0000_0000) held = 1'b0;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!held) $display("FAIL zero_prev_held got 0 want 1"); else n_pass++;
    n_checks++;
    if (cyc !== 33 || result !== e || e !== 64'd0)
      $display("FAIL zero_result got %h lat %0d want 0 lat 33", result, cyc);
    else n_pass++;
  endtask

  task automatic test_ignored_start;
    int dones;
    logic [63:0] got;
    logic [63:0] e;
    issue(32'd11, 32'd13, 1'b0);
    dones = 0;
    got = 64'd0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge CLK);
      #1;
      if (i == 5) begin start = 1'b1; a = 32'd7; b = 32'd7; end
      if (i == 9) start = 1'b0;
      if (i == 20) begin a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; end
      if (done) begin dones++; got = result; end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (dones !== 1) $display("FAIL ignored_done_count got %0d want 1", dones); else n_pass++;
    n_checks++;
    if (got !== e) $display("FAIL ignored_result got %h want %h", got, e); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [63:0] e;
    issue(32'd100, 32'd200, 1'b0);
    repeat (10) @(posedge CLK);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0)
      $display("FAIL resetmid_async got busy %0b done %0b result %h want 0 0 0", busy, done, result);
    else n_pass++;
    @(negedge CLK);
    reset = 1'b1;
    wait_done(cyc);
    n_checks++;
    if (cyc !== -1) $display("FAIL resetmid_no_done got done at %0d want none", cyc); else n_pass++;
    issue(32'd6, 32'd7, 1'b0);
    wait_done(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 33 || result !== e || e !== 64'd42)
      $display("FAIL resetmid_after got %h lat %0d want 42 lat 33", result, cyc);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] e;
    issue(32'd2, 32'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== (k == 0 ? 33 : 34) || result !== e)
        $display("FAIL b2b_%0d got %h interval %0d want %h interval %0d", k, result, cyc, e, (k == 0 ? 33 : 34));
      else n_pass++;
      // The next request is accepted on the IDLE edge that follows done.
      if (k < 2) exp_q.push_back(model(32'd2, 32'd3));
      else start = 1'b0;
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== -1) $display("FAIL b2b_stop got done at %0d want none", cyc); else n_pass++;
  endtask

  task automatic test_random;
    int cyc;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] e;
    for (int k = 0; k < 6; k++) begin
      x = $urandom;
      y = $urandom;
      issue(x, y, 1'b0);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== 33 || result !== e)
        $display("FAIL random_%0d %h*%h got %h lat %0d want %h", k, x, y, result, cyc, e);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
